// File: rtl/bcx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcx_pkg
// Brief    : Shared widths, dispatcher state encoding and nonce arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
package bcx_pkg;

    localparam int BLOCK_W    = 352;
    localparam int MIDSTATE_W = 256;
    localparam int TAIL_W     = 96;
    localparam int NONCE_W    = 32;

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_RUN  = 2'd1;
    localparam logic [1:0] C_ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = C_ST_IDLE,
        RUN  = C_ST_RUN,
        DONE = C_ST_DONE
    } dispatch_state_t;

    // Bit NONCE_W of the result flags that the nonce space has been exhausted.
    function automatic logic [NONCE_W:0] nonce_add(
        input logic [NONCE_W-1:0] nonce,
        input logic [NONCE_W-1:0] step
    );
        return {1'b0, nonce} + {1'b0, step};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ff_ar.sv
`default_nettype none
// ============================================================================
// Module   : ff_ar
// Brief    : Enabled register with asynchronous active-high reset.
// Revision : 1.0 - initial release
// ============================================================================
module ff_ar #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/work_dispatcher_nonce_counter.sv
`default_nettype none
// ============================================================================
// Module   : nonce_counter
// Brief    : Job nonce register; loads a start value and advances by a step,
//            flagging wrap instead of rolling over.
// Revision : 1.0 - initial release
// ============================================================================
module nonce_counter
    import bcx_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               advance,
    input  logic [NONCE_W-1:0] start,
    input  logic [NONCE_W-1:0] step,
    output logic [NONCE_W-1:0] nonce,
    output logic               wrap
);

    logic [NONCE_W:0]   w_sum;
    logic               w_en;
    logic [NONCE_W-1:0] w_d;
    logic [NONCE_W-1:0] r_nonce;

    assign w_sum = nonce_add(r_nonce, step);
    assign wrap  = w_sum[NONCE_W];

    // On wrap the final nonce is kept; the caller retires the job instead.
    assign w_en  = load | (advance & ~wrap);
    assign w_d   = load ? start : w_sum[NONCE_W-1:0];

    ff_ar #(
        .WIDTH     (NONCE_W),
        .RESET_VAL ('0)
    ) u_nonce_ff (
        .clk (clk),
        .rst (rst),
        .en  (w_en),
        .d   (w_d),
        .q   (r_nonce)
    );

    assign nonce = r_nonce;

endmodule
`default_nettype wire

// File: rtl/work_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : work_dispatcher
// Brief    : Captures an upstream block, streams nonce-iterated jobs to the
//            hash core and holds the hit/exhaustion result until acknowledged.
// Revision : 1.0 - initial release
// ============================================================================
module work_dispatcher
    import bcx_pkg::*;
#(
    parameter logic [NONCE_W-1:0] NONCE_START = 32'h0000_0000,
    parameter logic [NONCE_W-1:0] NONCE_STEP  = 32'h0000_0001
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  full,
    input  logic [BLOCK_W-1:0]    block_in,
    output logic                  read,
    input  logic                  core_ready,
    output logic                  job_valid,
    output logic [MIDSTATE_W-1:0] midstate,
    output logic [TAIL_W-1:0]     tail,
    output logic [NONCE_W-1:0]    nonce,
    input  logic                  hit,
    input  logic [NONCE_W-1:0]    hit_nonce,
    output logic                  result_valid,
    output logic [NONCE_W-1:0]    result_nonce,
    output logic                  exhausted,
    input  logic                  result_ack
);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  w_idle;
    logic                  w_run;
    logic                  w_done;
    logic                  w_capture;
    logic                  w_issue;
    logic                  w_wrap;
    logic                  w_finish_hit;
    logic                  w_finish_wrap;
    logic                  w_finish;
    logic                  w_ack;
    logic [NONCE_W-1:0]    w_result_d;
    logic [NONCE_W-1:0]    r_result_nonce;
    logic                  r_exhausted;
    logic [MIDSTATE_W-1:0] r_midstate;
    logic [TAIL_W-1:0]     r_tail;

    assign w_idle        = (r_state == IDLE);
    assign w_run         = (r_state == RUN);
    assign w_done        = (r_state == DONE);
    assign w_capture     = w_idle & full;
    assign w_issue       = w_run & core_ready;
    assign w_finish_hit  = w_run & hit;
    // A hit on the same edge as the wrap takes precedence.
    assign w_finish_wrap = w_issue & w_wrap & ~hit;
    assign w_finish      = w_finish_hit | w_finish_wrap;
    assign w_ack         = w_done & result_ack;

    // ---------------------------------------------------------------- state
    ff_ar #(
        .WIDTH     (2),
        .RESET_VAL (C_ST_IDLE)
    ) u_state_ff (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (w_state_nxt),
        .q   (r_state)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (full) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_finish) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (result_ack) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Gating read with rst keeps the upstream block intact across a reset.
    always_comb begin
        read         = 1'b0;
        job_valid    = 1'b0;
        result_valid = 1'b0;
        case (r_state)
            IDLE:    read         = full & ~rst;
            RUN:     job_valid    = 1'b1;
            DONE:    result_valid = 1'b1;
            default: read         = 1'b0;
        endcase
    end

    // ------------------------------------------------------------- job data
    ff_ar #(
        .WIDTH     (MIDSTATE_W),
        .RESET_VAL ('0)
    ) u_midstate_ff (
        .clk (clk),
        .rst (rst),
        .en  (w_capture),
        .d   (block_in[MIDSTATE_W-1:0]),
        .q   (r_midstate)
    );

    ff_ar #(
        .WIDTH     (TAIL_W),
        .RESET_VAL ('0)
    ) u_tail_ff (
        .clk (clk),
        .rst (rst),
        .en  (w_capture),
        .d   (block_in[BLOCK_W-1:MIDSTATE_W]),
        .q   (r_tail)
    );

    nonce_counter u_nonce_counter (
        .clk     (clk),
        .rst     (rst),
        .load    (w_capture),
        .advance (w_issue),
        .start   (NONCE_START),
        .step    (NONCE_STEP),
        .nonce   (nonce),
        .wrap    (w_wrap)
    );

    // --------------------------------------------------------------- result
    assign w_result_d = w_finish_hit ? hit_nonce : '0;

    ff_ar #(
        .WIDTH     (NONCE_W),
        .RESET_VAL ('0)
    ) u_result_nonce_ff (
        .clk (clk),
        .rst (rst),
        .en  (w_finish),
        .d   (w_result_d),
        .q   (r_result_nonce)
    );

    ff_ar #(
        .WIDTH     (1),
        .RESET_VAL (1'b0)
    ) u_exhausted_ff (
        .clk (clk),
        .rst (rst),
        .en  (w_finish | w_ack),
        .d   (w_finish_wrap),
        .q   (r_exhausted)
    );

    assign midstate     = r_midstate;
    assign tail         = r_tail;
    assign result_nonce = r_result_nonce;
    assign exhausted    = r_exhausted;

endmodule
`default_nettype wire

// File: tb/tb_work_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_work_dispatcher
// Brief    : Three dispatchers with different nonce parameters driven by shared
//            directed and random stimulus, compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_work_dispatcher;

    localparam int N = 3;
    localparam logic [31:0] STARTS [N] = '{32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFE};
    localparam logic [31:0] STEPS  [N] = '{32'h0000_0001, 32'h0000_0004, 32'h0000_0001};

    logic         clk = 1'b0;
    logic         rst;
    logic         full;
    logic [351:0] block_in;
    logic         core_ready;
    logic         hit;
    logic [31:0]  hit_nonce;
    logic         result_ack;

    logic [N-1:0] read_v;
    logic [N-1:0] job_valid_v;
    logic [N-1:0] result_valid_v;
    logic [N-1:0] exhausted_v;
    logic [255:0] midstate_v     [N];
    logic [95:0]  tail_v         [N];
    logic [31:0]  nonce_v        [N];
    logic [31:0]  result_nonce_v [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        work_dispatcher #(
            .NONCE_START (STARTS[g]),
            .NONCE_STEP  (STEPS[g])
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .full         (full),
            .block_in     (block_in),
            .read         (read_v[g]),
            .core_ready   (core_ready),
            .job_valid    (job_valid_v[g]),
            .midstate     (midstate_v[g]),
            .tail         (tail_v[g]),
            .nonce        (nonce_v[g]),
            .hit          (hit),
            .hit_nonce    (hit_nonce),
            .result_valid (result_valid_v[g]),
            .result_nonce (result_nonce_v[g]),
            .exhausted    (exhausted_v[g]),
            .result_ack   (result_ack)
        );
    end

    // ------------------------------------------------------------ reference
    // m_mode: 0 = waiting for a block, 1 = issuing jobs, 2 = holding a result
    int          m_mode  [N];
    logic [255:0] m_mid  [N];
    logic [95:0]  m_tail [N];
    logic [31:0]  m_nonce[N];
    logic [31:0]  m_rn   [N];
    bit           m_exh  [N];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [351:0] obs, input logic [351:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_mode[i]  = 0;
            m_mid[i]   = '0;
            m_tail[i]  = '0;
            m_nonce[i] = '0;
            m_rn[i]    = '0;
            m_exh[i]   = 1'b0;
        end
    endtask

    task automatic model_edge();
        longint unsigned sum;
        for (int i = 0; i < N; i++) begin
            case (m_mode[i])
                0: if (full) begin
                    m_mid[i]   = block_in[255:0];
                    m_tail[i]  = block_in[351:256];
                    m_nonce[i] = STARTS[i];
                    m_mode[i]  = 1;
                end
                1: begin
                    sum = longint'(m_nonce[i]) + longint'(STEPS[i]);
                    if (hit) begin
                        m_mode[i] = 2;
                        m_rn[i]   = hit_nonce;
                        m_exh[i]  = 1'b0;
                    end else if (core_ready) begin
                        if (sum > 64'h0000_0000_FFFF_FFFF) begin
                            m_mode[i] = 2;
                            m_rn[i]   = 32'h0;
                            m_exh[i]  = 1'b1;
                        end else begin
                            m_nonce[i] = sum[31:0];
                        end
                    end
                end
                default: if (result_ack) begin
                    m_mode[i] = 0;
                    m_exh[i]  = 1'b0;
                end
            endcase
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            check($sformatf("read[%0d]", i), read_v[i], (m_mode[i] == 0) && full && !rst);
            check($sformatf("job_valid[%0d]", i), job_valid_v[i], m_mode[i] == 1);
            check($sformatf("result_valid[%0d]", i), result_valid_v[i], m_mode[i] == 2);
            check($sformatf("exhausted[%0d]", i), exhausted_v[i], m_exh[i]);
            check($sformatf("midstate[%0d]", i), midstate_v[i], m_mid[i]);
            check($sformatf("tail[%0d]", i), tail_v[i], m_tail[i]);
            if (m_mode[i] == 1) check($sformatf("nonce[%0d]", i), nonce_v[i], m_nonce[i]);
            if (m_mode[i] == 2) check($sformatf("result_nonce[%0d]", i), result_nonce_v[i], m_rn[i]);
        end
    endtask

    // One clock: drive at negedge, compare, then advance the model at posedge.
    task automatic cycle(input logic f, input logic [351:0] blk, input logic cr,
                         input logic h, input logic [31:0] hn, input logic ack);
        @(negedge clk);
        full       = f;
        block_in   = blk;
        core_ready = cr;
        hit        = h;
        hit_nonce  = hn;
        result_ack = ack;
        #1;
        check_all();
        @(posedge clk);
        model_edge();
    endtask

    function automatic logic [351:0] rand_block();
        logic [351:0] b;
        for (int w = 0; w < 11; w++) b[32*w +: 32] = $urandom;
        return b;
    endfunction

    logic [351:0] ramp;
    logic [351:0] blk2;
    int           cr_pat [5] = '{1, 0, 0, 1, 1};

    initial begin
        rst        = 1'b1;
        full       = 1'b0;
        block_in   = '0;
        core_ready = 1'b0;
        hit        = 1'b0;
        hit_nonce  = '0;
        result_ack = 1'b0;
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Capture of a byte-ramp block
        for (int k = 0; k < 44; k++) ramp[8*k +: 8] = 8'(k);
        cycle(1'b1, ramp, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        check("cap_mid_lo", midstate_v[0][7:0], 8'h00);
        check("cap_mid_hi", midstate_v[0][255:248], 8'h1F);
        check("cap_tail_lo", tail_v[0][7:0], 8'h20);
        check("cap_tail_hi", tail_v[0][95:88], 8'h2B);
        check("cap_nonce", nonce_v[0], 32'h0);
        check("cap_jv", job_valid_v[0], 1'b1);

        // Stall pattern; DUT 2 wraps on the fourth issue slot
        for (int s = 0; s < 5; s++) cycle(1'b0, '0, cr_pat[s][0], 1'b0, 32'h0, 1'b0);
        #1;
        check("stall_nonce_s1", nonce_v[0], 32'd3);
        check("stall_nonce_s4", nonce_v[1], 32'd12);
        check("wrap_exh", exhausted_v[2], 1'b1);
        check("wrap_rn", result_nonce_v[2], 32'h0);

        // Advance DUT 0 to nonce 5, then hit
        cycle(1'b0, '0, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1, 32'h0000_1234, 1'b0);
        #1;
        check("hit_rn", result_nonce_v[0], 32'h1234);
        check("hit_rv", result_valid_v[0], 1'b1);
        check("hit_exh", exhausted_v[0], 1'b0);
        check("hit_jv", job_valid_v[0], 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0, 32'h0, 1'b0);

        // Hit on the wrapping edge of DUT 2 wins
        cycle(1'b1, rand_block(), 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1, 32'h0000_ABCD, 1'b0);
        #1;
        check("hitwrap_exh", exhausted_v[2], 1'b0);
        check("hitwrap_rn", result_nonce_v[2], 32'hABCD);

        // Backpressure: full stays high through DONE, block read after ack
        blk2 = rand_block();
        for (int s = 0; s < 3; s++) cycle(1'b1, blk2, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, blk2, 1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, blk2, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int s = 0; s < 3; s++) cycle(1'b0, '0, 1'b1, 1'b0, 32'h0, 1'b0);

        // Asynchronous reset between edges while jobs are running
        @(negedge clk);
        full = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < N; i++) begin
            check($sformatf("arst_jv[%0d]", i), job_valid_v[i], 1'b0);
            check($sformatf("arst_rv[%0d]", i), result_valid_v[i], 1'b0);
            check($sformatf("arst_nonce[%0d]", i), nonce_v[i], 32'h0);
            check($sformatf("arst_read[%0d]", i), read_v[i], 1'b0);
        end
        @(negedge clk);
        full = 1'b0;
        rst  = 1'b0;
        for (int s = 0; s < 3; s++) cycle(1'b0, '0, 1'b1, 1'b0, 32'h0, 1'b0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            cycle(($urandom_range(0, 2) == 0), rand_block(), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 15) == 0), $urandom, ($urandom_range(0, 2) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
